// File: rtl/dc_fpp_seq.sv
// Sequencer/arbiter sharing the dc_fpp 64x16 scratch RAM between the FPP engine (E) and host port (H).
// Define DC_FPP_FIXPRIO_EN for fixed E-over-H priority; otherwise ties are settled round-robin.
module dc_fpp_seq #(
    parameter int RR_INIT   = 0,
    parameter int ZERO_FILL = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        e_req,
    input  logic        e_we,
    input  logic [3:0]  e_reg,
    input  logic [1:0]  e_len,
    input  logic [63:0] e_wdata,
    output logic        e_ack,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [3:0]  h_reg,
    input  logic [1:0]  h_len,
    input  logic [63:0] h_wdata,
    output logic        h_ack,
    output logic [63:0] rdata,
    output logic        busy,
    output logic [5:0]  ram_addr,
    output logic [15:0] ram_data,
    output logic        ram_wren,
    output logic        ram_rden,
    input  logic [15:0] ram_q
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, ACK} state_t;

    state_t      state, state_nxt;
    logic        any_req, pick_h, sel_we;
    logic [1:0]  sel_len;
    logic        gnt_h, op_we;
    logic [3:0]  op_reg;
    logic [1:0]  op_len, k;
    logic [63:0] op_wdata;
    logic        rd_pend;
    logic [1:0]  rd_idx;
`ifndef DC_FPP_FIXPRIO_EN
    logic        rr;
`endif

    function automatic logic [15:0] get_word(input logic [63:0] v, input logic [1:0] i);
        case (i)
            2'd0:    get_word = v[63:48];
            2'd1:    get_word = v[47:32];
            2'd2:    get_word = v[31:16];
            default: get_word = v[15:0];
        endcase
    endfunction

    function automatic logic [63:0] put_word(input logic [63:0] v, input logic [1:0] i,
                                             input logic [15:0] w);
        put_word = v;
        case (i)
            2'd0:    put_word[63:48] = w;
            2'd1:    put_word[47:32] = w;
            2'd2:    put_word[31:16] = w;
            default: put_word[15:0]  = w;
        endcase
    endfunction

    assign any_req = e_req | h_req;
`ifdef DC_FPP_FIXPRIO_EN
    assign pick_h  = h_req & ~e_req;
`else
    assign pick_h  = h_req & (~e_req | rr);
`endif
    assign sel_we  = pick_h ? h_we : e_we;
    assign sel_len = pick_h ? h_len : e_len;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = RUN;
            RUN:  if (k == op_len) state_nxt = op_we ? ACK : WAIT;
            WAIT: state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch: only the granting cycle looks at the request-side inputs.
    always_ff @(posedge clock) begin
        if (state == IDLE && any_req) begin
            gnt_h    <= pick_h;
            op_we    <= sel_we;
            op_reg   <= pick_h ? h_reg : e_reg;
            op_len   <= (sel_len == 2'd2) ? 2'd3 : sel_len;
            op_wdata <= pick_h ? h_wdata : e_wdata;
        end
    end

    // Read words return one cycle after their rden, so capture trails the issuing access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k       <= 2'd0;
            rd_pend <= 1'b0;
            rd_idx  <= 2'd0;
            rdata   <= 64'd0;
`ifndef DC_FPP_FIXPRIO_EN
            rr      <= 1'(RR_INIT);
`endif
        end else begin
            rd_pend <= (state == RUN) && !op_we;
            rd_idx  <= k;
            if (state == IDLE && any_req) begin
                k <= 2'd0;
            end else if (state == RUN && k != op_len) begin
                k <= k + 2'd1;
            end
            if (state == IDLE && any_req && !sel_we && ZERO_FILL != 0) begin
                rdata <= 64'd0;
            end else if (rd_pend) begin
                rdata <= put_word(rdata, rd_idx, ram_q);
            end
`ifndef DC_FPP_FIXPRIO_EN
            if (state == ACK) rr <= ~gnt_h;
`endif
        end
    end

    assign busy     = (state != IDLE);
    assign e_ack    = (state == ACK) && !gnt_h;
    assign h_ack    = (state == ACK) && gnt_h;
    assign ram_wren = (state == RUN) && op_we;
    assign ram_rden = (state == RUN) && !op_we;
    assign ram_addr = (state == RUN) ? {op_reg, k} : 6'd0;
    assign ram_data = ram_wren ? get_word(op_wdata, k) : 16'd0;

endmodule
